// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with grant hold/release; optional hold timeout (RR_ARB_TIMEOUT_EN)
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       done,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       gnt_valid,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       timeout
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic               gnt_valid_d;
    logic [IDW-1:0]     gnt_id_d;
    logic               timeout_d;

    logic               found;
    logic [IDW-1:0]     pick;
    logic [IDW:0]       sum;
    logic [IDW-1:0]     idx;
    logic               user_release;
    logic               limit_hit;
    logic [IDW-1:0]     next_ptr;

    // Scan from ptr upward with wrap; sum never exceeds 2*NUM_REQ-2 so one subtraction suffices.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr_q} + (IDW+1)'(i);
            if (sum >= (IDW+1)'(NUM_REQ)) begin
                sum = sum - (IDW+1)'(NUM_REQ);
            end
            idx = sum[IDW-1:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign user_release = done || !req[gnt_id];
    assign next_ptr     = (gnt_id == IDW'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD+1);
    logic [CW-1:0] hold_q, hold_d;

    assign limit_hit = (hold_q == CW'(MAX_HOLD-1));

    always_comb begin
        hold_d = '0;
        if (state_q == GRANT && !user_release && !limit_hit) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    logic unused_max_hold;
    assign unused_max_hold = (MAX_HOLD != 0);
    assign limit_hit       = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt;
        gnt_valid_d = gnt_valid;
        gnt_id_d    = gnt_id;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = GRANT;
                    gnt_d       = NUM_REQ'(1) << pick;
                    gnt_valid_d = 1'b1;
                    gnt_id_d    = pick;
                end
            end
            GRANT: begin
                if (user_release || limit_hit) begin
                    state_d     = IDLE;
                    ptr_d       = next_ptr;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    gnt_id_d    = '0;
                    // A normal release on the limit edge wins over the forced one.
                    timeout_d   = !user_release;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                gnt_id_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt       <= gnt_d;
            gnt_valid <= gnt_valid_d;
            gnt_id    <= gnt_id_d;
            timeout   <= timeout_d;
        end
    end
endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - directed self-checking bench for rr_arbiter
module tb_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    rr_arbiter #(.NUM_REQ(4), .MAX_HOLD(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: gnt=%b valid=%b id=%0d timeout=%b, required 0000/0/0/0", gnt, gnt_valid, gnt_id, timeout);
        end
    endtask

    task automatic test_basic();
        do_reset();
        req = 4'b1010;
        tick();
        checks++;
        if (gnt !== 4'b0010 || gnt_valid !== 1'b1 || gnt_id !== 2'd1) begin
            errors++;
            $display("FAIL basic_first: gnt=%b valid=%b id=%0d, required 0010/1/1", gnt, gnt_valid, gnt_id);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL basic_gap: gnt=%b valid=%b id=%0d, required 0000/0/0", gnt, gnt_valid, gnt_id);
        end
        tick();
        checks++;
        if (gnt !== 4'b1000 || gnt_valid !== 1'b1 || gnt_id !== 2'd3) begin
            errors++;
            $display("FAIL basic_second: gnt=%b valid=%b id=%0d, required 1000/1/3", gnt, gnt_valid, gnt_id);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_ids [5];
        exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (gnt_id !== exp_ids[k] || gnt !== (4'b0001 << exp_ids[k]) || gnt_valid !== 1'b1) begin
                errors++;
                $display("FAIL rotate_grant[%0d]: gnt=%b id=%0d, required id %0d", k, gnt, gnt_id, exp_ids[k]);
            end
            done = 1'b1;
            tick();
            done = 1'b0;
            checks++;
            if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
                errors++;
                $display("FAIL rotate_gap[%0d]: gnt=%b valid=%b, required 0000/0", k, gnt, gnt_valid);
            end
        end
    endtask

    task automatic test_req_drop();
        do_reset();
        req = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
            errors++;
            $display("FAIL drop_grant: gnt=%b id=%0d, required 0100/2", gnt, gnt_id);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_release: gnt=%b valid=%b, required 0000/0", gnt, gnt_valid);
        end
        req = 4'b0101;
        tick();
        checks++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL drop_wrap: gnt=%b id=%0d, required 0001/0", gnt, gnt_id);
        end
    endtask

    task automatic test_hold();
        do_reset();
        req = 4'b0001;
        tick();
        for (int k = 0; k < 10; k++) begin
            req = {3'($urandom_range(0, 7)), 1'b1};
            tick();
            checks++;
            if (gnt !== 4'b0001 || gnt_id !== 2'd0 || gnt_valid !== 1'b1) begin
                errors++;
                $display("FAIL hold[%0d]: gnt=%b id=%0d req=%b, required 0001/0", k, gnt, gnt_id, req);
            end
        end
    endtask

    task automatic test_done_idle();
        do_reset();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_idle: gnt=%b valid=%b, required 0000/0", gnt, gnt_valid);
        end
        req = 4'b0011;
        tick();
        checks++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL done_idle_ptr: gnt=%b id=%0d, required 0001/0", gnt, gnt_id);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b1010;
        done = 1'b1;
        tick();
        tick();
        done = 1'b0;
        req = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL areset_pre: gnt=%b, required 0100", gnt);
        end
        req = 4'b1100;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL areset_drop: gnt=%b valid=%b id=%0d, required 0000/0/0", gnt, gnt_valid, gnt_id);
        end
        #1;
        rst = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
            errors++;
            $display("FAIL areset_regrant: gnt=%b id=%0d, required 0100/2", gnt, gnt_id);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0010;
        tick();
`ifdef RR_ARB_TIMEOUT_EN
        for (int k = 1; k < 16; k++) begin
            tick();
            checks++;
            if (gnt !== 4'b0010 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL to_hold[%0d]: gnt=%b timeout=%b, required 0010/0", k, gnt, timeout);
            end
        end
        tick();
        checks++;
        if (gnt !== 4'b0000 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL to_fire: gnt=%b timeout=%b, required 0000/1", gnt, timeout);
        end
        tick();
        checks++;
        if (timeout !== 1'b0 || gnt !== 4'b0010) begin
            errors++;
            $display("FAIL to_after: gnt=%b timeout=%b, required 0010/0", gnt, timeout);
        end
        for (int k = 1; k < 16; k++) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (gnt !== 4'b0000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_precedence: gnt=%b timeout=%b, required 0000/0", gnt, timeout);
        end
`else
        for (int k = 0; k < 120; k++) begin
            tick();
            checks++;
            if (gnt !== 4'b0010 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL no_timeout[%0d]: gnt=%b timeout=%b, required 0010/0", k, gnt, timeout);
            end
        end
`endif
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_req_drop();
        test_hold();
        test_done_idle();
        test_async_reset();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
